bhargava_uart_host: RTL and testbench
=====================================

// Module: bhargava_uart_host
//
// PURPOSE
// Host-side UART loader for the bhargava UART bitstream: serialises the 8-byte key, the mode byte,
// then payload bytes, and closes the stream with one deliberately bad-parity frame (end marker).
// Sits in bench/loader designs driving the device's rx_in.
// Self-contained serialiser; generic uart_tx cannot force a parity error.
//
// PARAMETERS
// CLK_FREQ   200       clock frequency in MHz
// BAUD_RATE  256000    bit rate; DIV = (CLK_FREQ*1_000_000)/BAUD_RATE, truncated (781 at defaults)
// PARITY     "ODD"     "ODD" or "EVEN" only; "NONE" unsupported (end marker needs parity)
//
// PORTS
// clk              in   1   system clock
// rst_n            in   1   asynchronous active-low reset
// start            in   1   pulse; begins a session when idle, ignored otherwise
// key_in           in   64  DES key, sampled on accepted start
// mode_in          in   1   mode bit, sampled on accepted start
// data_in          in   8   payload byte
// data_valid       in   1   payload byte present
// data_ready       out  1   payload byte accepted when data_valid && data_ready
// stream_end_req   in   1   level; request end marker, held until done
// tx_out           out  1   serial line, idle high
// busy             out  1   high from accepted start until done
// done             out  1   one-cycle pulse after end-marker stop bit completes
// bytes_sent       out  16  payload bytes sent this session, wraps 0xFFFF->0
//
// BEHAVIOUR
// - Reset (async, any state): tx_out=1, busy=0, data_ready=0, done=0, bytes_sent=0, FSM=IDLE,
//   serialiser idle; a frame in progress is abandoned immediately.
// - Frame: start(0), 8 data bits LSB first, parity, one stop(1) = 11 bits, each exactly DIV cycles.
//   Parity: ODD -> ~^byte, EVEN -> ^byte; end-marker frame uses the inverted bit.
// - Serialiser: byte loaded cycle N -> tx_out start bit from cycle N+1; free again on the last
//   stop-bit cycle, so the next load gives the next start bit with no idle gap.
// - FSM states:
//   IDLE: busy=0; start -> latch key_in/mode_in, clear bytes_sent, busy=1, go KEY.
//   KEY:  send key[63:56] first ... key[7:0] last (3-bit counter); after 8th load -> MODE.
//   MODE: send {7'b0,mode_in}; on load -> DATA.
//   DATA: data_ready = serialiser free this cycle (combinational from serialiser state, registered
//         inputs only). Serialiser free and:
//         - data_valid -> load data_in, bytes_sent+1;
//         - else stream_end_req -> go END.
//         Data has priority when both high.
//   END:  load 0x00 with inverted parity; when its stop bit completes, pulse done, busy=0, go IDLE.
// - data_ready=0 outside DATA and while a frame is in flight.
// - start while busy: ignored, no effect on the running session.
// - stream_end_req outside DATA: no effect until DATA reached.
// - Zero-payload session legal: KEY, MODE, END.
// - Total session length (n payload bytes, no stalls): (10+n)*11*DIV cycles from start to done.
//
// TESTING (sim overrides CLK_FREQ=1, BAUD_RATE=100000 -> DIV=10)
// 1 Reset: rst_n=0 mid-frame -> tx_out=1, busy=0, data_ready=0 same cycle, no resumed frame.
// 2 start, key=64'h0123456789ABCDEF, mode=1, no data, end_req held:
//   -> bytes 01,23,45,67,89,AB,CD,EF,01, then 00 with parity bit 0 (ODD);
//   -> done exactly 10*110 cycles after start.
// 3 Payload A5,3C,FF streamed with data_valid always high:
//   -> frames back-to-back, no gap; ODD parity bits 1,1,1; bytes_sent=3 at done.
// 4 data_valid dropped 37 cycles between payload bytes -> tx_out held high in gap,
//   data_ready high throughout gap.
// 5 data_valid and stream_end_req rise same cycle -> data byte sent, then end marker; bytes_sent=1.
// 6 start pulsed mid-KEY with different key -> ignored, original key bytes continue;
//   PARITY="EVEN" rerun of 2 -> end-frame parity bit 1.

Source files
------------

// File: rtl/bhargava_uart_host.sv
// Host-side UART loader: streams an 8-byte key, a mode byte and payload bytes, then closes the
// session with a single frame whose parity bit is deliberately wrong (the end marker).
module bhargava_uart_host #(
    parameter int    CLK_FREQ  = 200,
    parameter int    BAUD_RATE = 256000,
    parameter string PARITY    = "ODD"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        mode_in,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        stream_end_req,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] bytes_sent
);

    localparam int             DIV     = (CLK_FREQ * 1000000) / BAUD_RATE;
    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);
    localparam logic           PAR_ODD = (PARITY == "ODD") ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_MODE, S_DATA, S_END} state_t;

    function automatic logic frame_parity(input logic [7:0] b, input logic odd, input logic inv);
        return (odd ? ~^b : ^b) ^ inv;
    endfunction

    state_t        r_state;
    state_t        w_next_state;
    logic [63:0]   r_key;
    logic          r_mode;
    logic [2:0]    r_key_cnt;
    logic          r_busy;
    logic          r_done;
    logic [15:0]   r_bytes;
    logic          r_tx;
    logic          r_ser_busy;
    logic [9:0]    r_frame;
    logic [3:0]    r_bit_cnt;
    logic [CW-1:0] r_div_cnt;

    logic          w_ser_last;
    logic          w_ser_free;
    logic          w_start_acc;
    logic          w_load;
    logic [7:0]    w_load_byte;
    logic          w_load_inv;
    logic          w_accept;
    logic          w_finish;
    logic          w_data_ready;
    logic [7:0]    w_key_byte;

    // The serialiser counts as free on its final stop-bit cycle so frames chain without a gap.
    assign w_ser_last = r_ser_busy && (r_bit_cnt == 4'd10) && (r_div_cnt == DIV_M1);
    assign w_ser_free = !r_ser_busy || w_ser_last;
    assign w_key_byte = r_key[{3'd7 - r_key_cnt, 3'b000} +: 8];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_KEY;
                     else       w_next_state = S_IDLE;
            S_KEY:   if (w_ser_free && (r_key_cnt == 3'd7)) w_next_state = S_MODE;
                     else                                    w_next_state = S_KEY;
            S_MODE:  if (w_ser_free) w_next_state = S_DATA;
                     else            w_next_state = S_MODE;
            S_DATA:  if (w_ser_free && !data_valid && stream_end_req) w_next_state = S_END;
                     else                                              w_next_state = S_DATA;
            S_END:   if (w_ser_last) w_next_state = S_IDLE;
                     else            w_next_state = S_END;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Per-state serialiser load requests and handshake; the first key byte goes out with start.
    always_comb begin
        w_start_acc  = 1'b0;
        w_load       = 1'b0;
        w_load_byte  = 8'h00;
        w_load_inv   = 1'b0;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_data_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_load      = 1'b1;
                    w_load_byte = key_in[63:56];
                end else begin
                    w_start_acc = 1'b0;
                end
            end
            S_KEY: begin
                if (w_ser_free) begin
                    w_load      = 1'b1;
                    w_load_byte = w_key_byte;
                end else begin
                    w_load = 1'b0;
                end
            end
            S_MODE: begin
                if (w_ser_free) begin
                    w_load      = 1'b1;
                    w_load_byte = {7'b0000000, r_mode};
                end else begin
                    w_load = 1'b0;
                end
            end
            S_DATA: begin
                w_data_ready = w_ser_free;
                if (w_ser_free && data_valid) begin
                    w_load      = 1'b1;
                    w_load_byte = data_in;
                    w_accept    = 1'b1;
                end else if (w_ser_free && stream_end_req) begin
                    w_load      = 1'b1;
                    w_load_byte = 8'h00;
                    w_load_inv  = 1'b1;
                end else begin
                    w_load = 1'b0;
                end
            end
            S_END: begin
                if (w_ser_last) w_finish = 1'b1;
                else            w_finish = 1'b0;
            end
            default: w_load = 1'b0;
        endcase
    end

    // Session bookkeeping: latched key/mode, key byte index, busy/done and payload count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key     <= 64'h0;
            r_mode    <= 1'b0;
            r_key_cnt <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bytes   <= 16'h0000;
        end else begin
            r_done <= w_finish;
            if (w_start_acc) begin
                r_key     <= key_in;
                r_mode    <= mode_in;
                r_key_cnt <= 3'd1;
                r_bytes   <= 16'h0000;
                r_busy    <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end
            if ((r_state == S_KEY) && w_load) r_key_cnt <= r_key_cnt + 3'd1;
            if (w_accept) r_bytes <= r_bytes + 16'd1;
        end
    end

    // Frame serialiser: start bit, 8 data bits LSB first, parity, stop; DIV cycles per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx       <= 1'b1;
            r_ser_busy <= 1'b0;
            r_frame    <= 10'h3FF;
            r_bit_cnt  <= 4'd0;
            r_div_cnt  <= '0;
        end else if (w_load) begin
            r_tx       <= 1'b0;
            r_ser_busy <= 1'b1;
            r_frame    <= {1'b1, frame_parity(w_load_byte, PAR_ODD, w_load_inv), w_load_byte};
            r_bit_cnt  <= 4'd0;
            r_div_cnt  <= '0;
        end else if (r_ser_busy) begin
            if (r_div_cnt == DIV_M1) begin
                r_div_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_ser_busy <= 1'b0;
                    r_tx       <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_tx      <= r_frame[0];
                    r_frame   <= {1'b1, r_frame[9:1]};
                end
            end else begin
                r_div_cnt <= r_div_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign tx_out     = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign bytes_sent = r_bytes;
    assign data_ready = w_data_ready;

endmodule

// File: tb/tb_bhargava_uart_host.sv
// Directed bench for bhargava_uart_host: decodes the serial line and compares every frame,
// its timing and the session outputs against hand-derived expectations (DIV=10).
module tb_bhargava_uart_host;

    localparam int DIV   = 10;
    localparam int FRAME = 11 * DIV;

    logic        clk = 1'b0, rst_n = 1'b0, start_cmd = 1'b0, mode_in = 1'b0;
    logic        data_valid = 1'b0, stream_end_req = 1'b0, use_even = 1'b0;
    logic [63:0] key_in = 64'h0;
    logic [7:0]  data_in = 8'h00;
    logic        start_o, start_e, ready_o, ready_e, tx_o, tx_e, busy_o, busy_e, done_o, done_e;
    logic [15:0] bytes_o, bytes_e;
    logic        w_ready, w_tx, w_busy, w_done;
    logic [15:0] w_bytes;

    assign start_o = start_cmd & ~use_even;
    assign start_e = start_cmd &  use_even;
    assign w_ready = use_even ? ready_e : ready_o;
    assign w_tx    = use_even ? tx_e    : tx_o;
    assign w_busy  = use_even ? busy_e  : busy_o;
    assign w_done  = use_even ? done_e  : done_o;
    assign w_bytes = use_even ? bytes_e : bytes_o;

    bhargava_uart_host #(.CLK_FREQ(1), .BAUD_RATE(100000), .PARITY("ODD")) u_odd (
        .clk(clk), .rst_n(rst_n), .start(start_o), .key_in(key_in), .mode_in(mode_in),
        .data_in(data_in), .data_valid(data_valid), .data_ready(ready_o),
        .stream_end_req(stream_end_req), .tx_out(tx_o), .busy(busy_o), .done(done_o),
        .bytes_sent(bytes_o));

    bhargava_uart_host #(.CLK_FREQ(1), .BAUD_RATE(100000), .PARITY("EVEN")) u_even (
        .clk(clk), .rst_n(rst_n), .start(start_e), .key_in(key_in), .mode_in(mode_in),
        .data_in(data_in), .data_valid(data_valid), .data_ready(ready_e),
        .stream_end_req(stream_end_req), .tx_out(tx_e), .busy(busy_e), .done(done_e),
        .bytes_sent(bytes_e));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit and records each frame with its start cycle.
    logic [7:0]  rx_byte_q[$];
    logic        rx_par_q[$];
    logic        rx_ok_q[$];
    int          rx_t_q[$];
    bit          rx_active = 1'b0;
    int          rx_cnt = 0, rx_t0 = 0;
    logic [10:0] rx_bits = 11'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (w_tx == 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_t0     = cyc;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % DIV == DIV / 2) rx_bits[rx_cnt / DIV] = w_tx;
            if (rx_cnt == 10 * DIV + DIV / 2) begin
                rx_byte_q.push_back(rx_bits[8:1]);
                rx_par_q.push_back(rx_bits[9]);
                rx_ok_q.push_back(rx_bits[10] & ~rx_bits[0]);
                rx_t_q.push_back(rx_t0);
                rx_active = 1'b0;
            end
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] pay [0:7];

    task automatic run_session(input string name, input logic [63:0] key, input logic mode,
                               input int n, input int gap, input int end_mode, input int restart_at);
        int base, c0, idx, pend, guard, gap_bad, gap_cyc, nfr, exp_dt;
        bit started;
        logic [63:0] sh;
        logic [7:0]  exp_b;
        logic        exp_p;
        base = rx_byte_q.size();
        data_valid = 1'b0;
        stream_end_req = (end_mode == 0);
        @(negedge clk);
        key_in = key; mode_in = mode; start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0; c0 = cyc;
        check({name, "_busy_after_start"}, {63'd0, w_busy}, 64'd1);
        idx = 0; pend = 0; guard = 0; gap_bad = 0; gap_cyc = 0; started = (end_mode != 2);
        while (!w_done && guard < 5000) begin
            start_cmd = (cyc - c0 == restart_at);
            if (start_cmd) begin
                key_in  = 64'hFEDCBA9876543210;
                mode_in = 1'b0;
            end
            if (!started && w_ready) begin
                started = 1'b1;
                stream_end_req = 1'b1;
            end
            data_valid = 1'b0;
            if (started && idx < n) begin
                if (pend > 0) begin
                    if (pend < gap || w_ready) begin
                        gap_cyc++;
                        if (!(w_tx === 1'b1 && w_ready === 1'b1)) gap_bad++;
                        pend--;
                    end
                end else begin
                    data_valid = 1'b1;
                    data_in = pay[idx];
                end
            end else if (started && end_mode == 1) begin
                stream_end_req = 1'b1;
            end
            if (data_valid && w_ready) begin
                idx++;
                pend = gap;
            end
            @(negedge clk);
            guard++;
        end
        start_cmd = 1'b0;
        check({name, "_done_seen"}, {63'd0, w_done}, 64'd1);
        check({name, "_latency"}, 64'(cyc - c0), 64'((10 + n) * FRAME + ((n > 1) ? (n - 1) * gap : 0)));
        check({name, "_bytes_sent"}, {48'd0, w_bytes}, 64'(n));
        check({name, "_busy_at_done"}, {63'd0, w_busy}, 64'd0);
        if (gap > 0) begin
            check({name, "_gap_line_idle_ready"}, 64'(gap_bad), 64'd0);
            check({name, "_gap_cycles"}, 64'(gap_cyc), 64'((n - 1) * gap));
        end
        stream_end_req = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check({name, "_done_pulse_width"}, {63'd0, w_done}, 64'd0);
        nfr = rx_byte_q.size() - base;
        check({name, "_frame_count"}, 64'(nfr), 64'(n + 10));
        for (int i = 0; i < nfr && i < n + 10; i++) begin
            if (i < 8) begin
                sh = key >> (56 - 8 * i);
                exp_b = sh[7:0];
            end else if (i == 8) begin
                exp_b = {7'b0000000, mode};
            end else if (i < 9 + n) begin
                exp_b = pay[i - 9];
            end else begin
                exp_b = 8'h00;
            end
            exp_p = (use_even ? ^exp_b : ~^exp_b) ^ (i == 9 + n);
            check($sformatf("%s_byte%0d", name, i), {56'd0, rx_byte_q[base + i]}, {56'd0, exp_b});
            check($sformatf("%s_par%0d", name, i), {63'd0, rx_par_q[base + i]}, {63'd0, exp_p});
            check($sformatf("%s_framing%0d", name, i), {63'd0, rx_ok_q[base + i]}, 64'd1);
            if (i > 0) begin
                exp_dt = (i >= 10 && i < 9 + n) ? FRAME + gap : FRAME;
                check($sformatf("%s_spacing%0d", name, i),
                      64'(rx_t_q[base + i] - rx_t_q[base + i - 1]), 64'(exp_dt));
            end
        end
    endtask

    initial begin
        int base, low_cnt;
        repeat (3) @(negedge clk);
        check("rst_tx", {63'd0, w_tx}, 64'd1);
        check("rst_busy", {63'd0, w_busy}, 64'd0);
        check("rst_ready", {63'd0, w_ready}, 64'd0);
        check("rst_done", {63'd0, w_done}, 64'd0);
        check("rst_bytes", {48'd0, w_bytes}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of the first key frame (bit d1 of 0x01, line low).
        key_in = 64'h0123456789ABCDEF; mode_in = 1'b1; start_cmd = 1'b1;
        @(negedge clk);
        start_cmd = 1'b0;
        repeat (24) @(negedge clk);
        check("t1_midframe_tx_low", {63'd0, w_tx}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("t1_async_tx", {63'd0, w_tx}, 64'd1);
        check("t1_async_busy", {63'd0, w_busy}, 64'd0);
        check("t1_async_ready", {63'd0, w_ready}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = rx_byte_q.size();
        low_cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (w_tx !== 1'b1) low_cnt++;
        end
        check("t1_no_resume_line", 64'(low_cnt), 64'd0);
        check("t1_no_resume_frames", 64'(rx_byte_q.size() - base), 64'd0);
        check("t1_idle_busy", {63'd0, w_busy}, 64'd0);

        run_session("t2", 64'h0123456789ABCDEF, 1'b1, 0, 0, 0, -1);
        check("t2_end_parity_odd", {63'd0, rx_par_q[rx_par_q.size() - 1]}, 64'd0);

        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
        run_session("t3", 64'h1122334455667788, 1'b0, 3, 0, 0, -1);

        pay[0] = 8'h5A; pay[1] = 8'hC3; pay[2] = 8'h81;
        run_session("t4", 64'h8000000000000001, 1'b1, 3, 37, 1, -1);

        pay[0] = 8'hAA;
        run_session("t5", 64'hDEADBEEFCAFEF00D, 1'b0, 1, 0, 2, -1);

        run_session("t6", 64'h0123456789ABCDEF, 1'b1, 0, 0, 0, 200);

        use_even = 1'b1;
        @(negedge clk);
        run_session("t6e", 64'h0123456789ABCDEF, 1'b1, 0, 0, 0, -1);
        check("t6e_end_parity_even", {63'd0, rx_par_q[rx_par_q.size() - 1]}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
